// File: rtl/single_cycle_cpu_display_pkg.sv
// Shared opcodes, instruction field widths, boot ROM image
// and seven-segment encoding for the teaching CPU board.
package single_cycle_cpu_display_pkg;

  localparam int XLEN  = 32;
  localparam int PC_W  = 4;
  localparam int OP_W  = 4;
  localparam int REG_W = 2;
  localparam int IMM_W = 16;
  localparam int NREG  = 4;
  localparam int NMEM  = 16;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADDI = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_SLT  = 4'h7,
    OP_LW   = 4'h8,
    OP_SW   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_J    = 4'hB
  } op_e;

  // Word 15 first: packed index matches the PC.
  localparam logic [15:0][XLEN-1:0] ROM = {
    32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000,
    32'hB000_0007, 32'h8400_0000,
    32'h90C0_0001, 32'h3D80_0000,
    32'h90C0_0000, 32'h2D80_0000,
    32'h1800_0003, 32'h1400_0005
  };

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] s;
    unique case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/single_cycle_cpu_display_core.sv
// Single-cycle core: PC, 4-entry register file, 16-word data
// memory and fixed ROM; state commits only on a step pulse.
module scpu_core
  import single_cycle_cpu_display_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              step,
  output logic [PC_W-1:0]   pc,
  output logic [XLEN-1:0]   instr,
  input  logic [REG_W-1:0]  rf_idx,
  output logic [XLEN-1:0]   rf_data,
  input  logic [3:0]        mem_idx,
  output logic [XLEN-1:0]   mem_data
);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  rf_q  [NREG];
  logic [XLEN-1:0]  mem_q [NMEM];

  op_e              op;
  logic [REG_W-1:0] rd, rs, rt;
  logic [IMM_W-1:0] imm;
  logic [XLEN-1:0]  simm, rs_v, rt_v, sum;
  logic [3:0]       addr;

  logic             wr_en;
  logic [XLEN-1:0]  wr_val;
  logic             mem_we;

  assign instr = ROM[pc_q];
  assign op    = op_e'(instr[31:28]);
  assign rd    = instr[27:26];
  assign rs    = instr[25:24];
  assign rt    = instr[23:22];
  assign imm   = instr[15:0];
  assign simm  = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};

  // rf_q[0] is reset to zero and never written.
  assign rs_v  = rf_q[rs];
  assign rt_v  = rf_q[rt];
  assign sum   = rs_v + simm;
  assign addr  = sum[3:0];

  assign pc       = pc_q;
  assign rf_data  = rf_q[rf_idx];
  assign mem_data = mem_q[mem_idx];

  always_comb begin
    pc_d   = pc_q + 4'd1;
    wr_en  = 1'b0;
    wr_val = '0;
    mem_we = 1'b0;
    unique case (op)
      OP_ADDI: begin wr_en = 1'b1; wr_val = sum;         end
      OP_ADD:  begin wr_en = 1'b1; wr_val = rs_v + rt_v; end
      OP_SUB:  begin wr_en = 1'b1; wr_val = rs_v - rt_v; end
      OP_AND:  begin wr_en = 1'b1; wr_val = rs_v & rt_v; end
      OP_OR:   begin wr_en = 1'b1; wr_val = rs_v | rt_v; end
      OP_XOR:  begin wr_en = 1'b1; wr_val = rs_v ^ rt_v; end
      OP_SLT: begin
        wr_en  = 1'b1;
        wr_val = {31'b0, $signed(rs_v) < $signed(rt_v)};
      end
      OP_LW:   begin wr_en = 1'b1; wr_val = mem_q[addr]; end
      OP_SW:   mem_we = 1'b1;
      OP_BEQ: begin
        if (rs_v == rt_v) pc_d = pc_q + 4'd1 + imm[3:0];
      end
      OP_J:    pc_d = imm[3:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      for (int i = 0; i < NMEM; i++) mem_q[i] <= '0;
    end else if (step) begin
      pc_q <= pc_d;
      if (wr_en && rd != '0) rf_q[rd] <= wr_val;
      if (mem_we) mem_q[addr] <= rt_v;
    end
  end

endmodule

// File: rtl/single_cycle_cpu_display.sv
// Board top: button step synchroniser, single-cycle core and
// 8-digit multiplexed hex display of PC/instr/register/memory.
module single_cycle_cpu_display
  import single_cycle_cpu_display_pkg::*;
#(
  parameter int SCAN_BITS = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_clk,
  input  logic [1:0] switch,
  input  logic [1:0] rf_switch,
  input  logic [3:0] mem_switch,
  output logic [7:0] figure,
  output logic [7:0] seg_signal
);

  logic [2:0]           sync_q;
  logic                 step;
  logic [SCAN_BITS-1:0] scan_q;
  logic [2:0]           digit;
  logic [3:0]           nib;
  logic [XLEN-1:0]      value;
  logic [7:0]           figure_d, seg_d;

  logic [PC_W-1:0]      pc;
  logic [XLEN-1:0]      instr, rf_data, mem_data;

  // Two sync stages, third bit is the edge-detect history.
  assign step = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[1:0], btn_clk};
  end

  scpu_core u_core (
    .clk      (clk),
    .resetn   (resetn),
    .step     (step),
    .pc       (pc),
    .instr    (instr),
    .rf_idx   (rf_switch),
    .rf_data  (rf_data),
    .mem_idx  (mem_switch),
    .mem_data (mem_data)
  );

  always_comb begin
    value = '0;
    unique case (switch)
      2'd0: value = {{(XLEN-PC_W){1'b0}}, pc};
      2'd1: value = instr;
      2'd2: value = rf_data;
      default: value = mem_data;
    endcase
  end

  assign digit    = scan_q[SCAN_BITS-1 -: 3];
  assign nib      = value[{digit, 2'b00} +: 4];
  assign figure_d = ~(8'b1 << digit);
  assign seg_d    = hex7(nib);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_q     <= '0;
      figure     <= 8'hFF;
      seg_signal <= 8'hFF;
    end else begin
      scan_q     <= scan_q + 1'b1;
      figure     <= figure_d;
      seg_signal <= seg_d;
    end
  end

endmodule

// File: tb/tb_single_cycle_cpu_display.sv
// Scoreboard bench: expected digit patterns are queued per display
// request and popped against one captured scan cycle.
module tb_single_cycle_cpu_display;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       btn_clk = 1'b0;
  logic [1:0] switch = 2'd0;
  logic [1:0] rf_switch = 2'd0;
  logic [3:0] mem_switch = 4'd0;
  logic [7:0] figure, seg_signal;

  int checks = 0;
  int passed = 0;

  logic [15:0] sb  [$];
  logic [15:0] obs [$];

  logic [7:0] seg_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  single_cycle_cpu_display #(.SCAN_BITS(3)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .btn_clk    (btn_clk),
    .switch     (switch),
    .rf_switch  (rf_switch),
    .mem_switch (mem_switch),
    .figure     (figure),
    .seg_signal (seg_signal)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push_exp(input logic [31:0] v);
    logic [7:0] f;
    for (int i = 0; i < 8; i++) begin
      f = ~(8'h01 << i);
      sb.push_back({f, seg_tab[v[4*i +: 4]]});
    end
  endtask

  // Captures one full scan starting at digit 0; x on timeout.
  task automatic capture();
    int n;
    n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    while (figure !== 8'hFE && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 8; i++) begin
      if (n >= 20) obs.push_back(16'hxxxx);
      else obs.push_back({figure, seg_signal});
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic step_btn();
    @(negedge clk);
    btn_clk = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    btn_clk = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic show(input logic [1:0] sw, input logic [3:0] idx,
                      input logic [31:0] v);
    switch = sw;
    rf_switch = idx[1:0];
    mem_switch = idx;
    push_exp(v);
    capture();
  endtask

  task automatic test_reset();
    logic [15:0] e, o;
    @(negedge clk);
    resetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({figure, seg_signal} !== 16'hFFFF)
        $display("FAIL reset_out: got %h want ffff", {figure, seg_signal});
      else passed++;
    end
    resetn = 1'b1;
    show(2'd0, 4'd0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) $display("FAIL reset_pc d%0d: got %h want %h", k, o, e);
      else passed++;
    end
  endtask

  task automatic test_regs();
    logic [15:0] e, o;
    logic [1:0]  ri [3] = '{2'd3, 2'd1, 2'd0};
    logic [31:0] rv [3] = '{32'd8, 32'd5, 32'd0};
    do_reset();
    repeat (3) step_btn();
    for (int s = 0; s < 3; s++) begin
      show(2'd2, {2'b0, ri[s]}, rv[s]);
      for (int k = 0; k < 8; k++) begin
        e = sb.pop_front(); o = obs.pop_front(); checks++;
        if (o !== e)
          $display("FAIL regs r%0d d%0d: got %h want %h", ri[s], k, o, e);
        else passed++;
      end
    end
  endtask

  task automatic test_mem();
    logic [15:0] e, o;
    logic [1:0]  sw [4] = '{2'd3, 2'd3, 2'd3, 2'd2};
    logic [3:0]  ix [4] = '{4'd0, 4'd1, 4'd15, 4'd1};
    logic [31:0] ev [4] = '{32'd8, 32'd2, 32'd0, 32'd8};
    repeat (4) step_btn();
    for (int s = 0; s < 4; s++) begin
      show(sw[s], ix[s], ev[s]);
      for (int k = 0; k < 8; k++) begin
        e = sb.pop_front(); o = obs.pop_front(); checks++;
        if (o !== e)
          $display("FAIL mem case%0d d%0d: got %h want %h", s, k, o, e);
        else passed++;
      end
    end
  endtask

  task automatic test_jump();
    logic [15:0] e, o;
    logic [1:0]  sw [2] = '{2'd0, 2'd1};
    logic [31:0] ev [2] = '{32'h7, 32'hB000_0007};
    repeat (3) step_btn();
    for (int s = 0; s < 2; s++) begin
      show(sw[s], 4'd0, ev[s]);
      for (int k = 0; k < 8; k++) begin
        e = sb.pop_front(); o = obs.pop_front(); checks++;
        if (o !== e)
          $display("FAIL jump sw%0d d%0d: got %h want %h", sw[s], k, o, e);
        else passed++;
      end
    end
  endtask

  task automatic test_held_and_masked();
    logic [15:0] e, o;
    do_reset();
    @(negedge clk);
    btn_clk = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    btn_clk = 1'b0;
    repeat (4) @(posedge clk);
    show(2'd0, 4'd0, 32'd1);
    show(2'd2, 4'd1, 32'd5);
    @(negedge clk);
    resetn = 1'b0;
    btn_clk = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    btn_clk = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    show(2'd0, 4'd0, 32'd0);
    for (int k = 0; k < 24; k++) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) $display("FAIL held_masked #%0d: got %h want %h", k, o, e);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] e, o;
    do_reset();
    repeat (5) step_btn();
    show(2'd2, 4'd3, 32'd2);
    show(2'd3, 4'd0, 32'd8);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({figure, seg_signal} !== 16'hFFFF)
      $display("FAIL async_reset: got %h want ffff", {figure, seg_signal});
    else passed++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    show(2'd0, 4'd0, 32'd0);
    show(2'd2, 4'd1, 32'd0);
    show(2'd2, 4'd3, 32'd0);
    show(2'd3, 4'd0, 32'd0);
    for (int k = 0; k < 48; k++) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e) $display("FAIL async_rst #%0d: got %h want %h", k, o, e);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_mem();
    test_jump();
    test_held_and_masked();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
